// File: rtl/std_fifo_push_arbiter_if.sv
// Push-side bundle between REQ producers, the arbiter and one std_fifo push port.
// master: producers/FIFO side; slave: the arbiter.
interface std_fifo_push_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int REQ     = 4,
  parameter int IDX_W   = 2,
  parameter int BURST_W = 3
);
  logic [REQ-1:0]       req;
  logic [REQ-1:0]       req_last;
  logic [REQ*WIDTH-1:0] req_d;
  logic [REQ-1:0]       grant;
  logic                 fifo_push;
  logic [WIDTH-1:0]     fifo_d;
  logic                 fifo_full;
  logic [IDX_W-1:0]     owner;
  logic                 locked;
  logic [BURST_W-1:0]   burst_cnt;

  modport master (
    output req, req_last, req_d, fifo_full,
    input  grant, fifo_push, fifo_d, owner, locked, burst_cnt
  );

  modport slave (
    input  req, req_last, req_d, fifo_full,
    output grant, fifo_push, fifo_d, owner, locked, burst_cnt
  );
endinterface

// File: rtl/std_fifo_push_arbiter.sv
// Round-robin write arbiter in front of a std_fifo push port; zero-latency grant.
// Define STD_FIFO_ARB_BURST_EN to enable burst locking (LOCKED state).
module std_fifo_push_arbiter #(
  parameter int WIDTH     = 8,
  parameter int REQ       = 4,
  parameter int IDX_W     = 2,
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 3
) (
  input logic                    clk,
  input logic                    rst,
  std_fifo_push_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

`ifdef STD_FIFO_ARB_BURST_EN
  localparam bit BURST_ON = (MAX_BURST > 1);
`else
  localparam bit BURST_ON = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0] cnt_inc;

  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [REQ-1:0]     grant;
  logic [WIDTH-1:0]   fifo_d;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % REQ);
  endfunction

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
    return (int'(i) == REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Grant selection: locked owner only, otherwise first requester from ptr upward.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (rst && !bus.fifo_full) begin
      if (state_q == LOCKED) begin
        gnt_any = bus.req[owner_q];
        gnt_idx = owner_q;
      end else begin
        for (int k = 0; k < REQ; k++) begin
          if (!gnt_any && bus.req[rr_idx(ptr_q, k)]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_idx(ptr_q, k);
          end
        end
      end
    end
  end

  always_comb begin
    grant  = '0;
    fifo_d = '0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
      fifo_d         = bus.req_d[int'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    cnt_inc     = burst_cnt_q + 1'b1;
    if (state_q == IDLE) begin
      // A single-word grant shows burst_cnt=1 for one cycle only.
      burst_cnt_d = '0;
      if (gnt_any) begin
        owner_d     = gnt_idx;
        burst_cnt_d = BURST_W'(1);
        if (BURST_ON && !bus.req_last[gnt_idx]) begin
          state_d = LOCKED;
        end else begin
          ptr_d = idx_next(gnt_idx);
        end
      end
    end else if (gnt_any) begin
      if (bus.req_last[owner_q] || cnt_inc == BURST_W'(MAX_BURST)) begin
        state_d     = IDLE;
        ptr_d       = idx_next(owner_q);
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.grant     = grant;
  assign bus.fifo_push = gnt_any;
  assign bus.fifo_d    = fifo_d;
  assign bus.owner     = owner_q;
  assign bus.burst_cnt = burst_cnt_q;
`ifdef STD_FIFO_ARB_BURST_EN
  assign bus.locked    = (state_q == LOCKED);
`else
  assign bus.locked    = 1'b0;
`endif

endmodule

// File: tb/tb_std_fifo_push_arbiter.sv
// Bench for std_fifo_push_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level arbitration model.
module tb_std_fifo_push_arbiter;
  localparam int WIDTH     = 8;
  localparam int REQ       = 4;
  localparam int IDX_W     = 2;
  localparam int MAX_BURST = 4;
  localparam int BURST_W   = 3;
`ifdef STD_FIFO_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_bad;
  int   cyc;

  // Model state: who holds the FIFO, where the round-robin search starts.
  bit   m_locked;
  int   m_ptr;
  int   m_owner;
  int   m_cnt;

  std_fifo_push_arbiter_if #(.WIDTH(WIDTH), .REQ(REQ), .IDX_W(IDX_W), .BURST_W(BURST_W)) bus ();

  std_fifo_push_arbiter #(
    .WIDTH(WIDTH), .REQ(REQ), .IDX_W(IDX_W), .MAX_BURST(MAX_BURST), .BURST_W(BURST_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Which producer should win this cycle (-1 for none).
  function automatic int model_pick();
    if (!rst || bus.fifo_full) return -1;
    if (m_locked) return bus.req[m_owner] ? m_owner : -1;
    for (int k = 0; k < REQ; k++) begin
      if (bus.req[(m_ptr + k) % REQ]) return (m_ptr + k) % REQ;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (!rst) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_cnt    = 0;
    end else if (g >= 0 && !m_locked) begin
      m_owner = g;
      m_cnt   = 1;
      if (BURST_EN && MAX_BURST > 1 && !bus.req_last[g]) m_locked = 1'b1;
      else m_ptr = (g + 1) % REQ;
    end else if (g >= 0) begin
      m_cnt = m_cnt + 1;
      if (bus.req_last[g] || m_cnt == MAX_BURST) begin
        m_locked = 1'b0;
        m_ptr    = (g + 1) % REQ;
        m_cnt    = 0;
      end
    end else if (!m_locked) begin
      m_cnt = 0;
    end
  endtask

  // Inputs are already driven; check at negedge, advance model at posedge.
  task automatic cycle();
    int               g;
    logic [REQ-1:0]   eg;
    logic [WIDTH-1:0] ed;
    @(negedge clk);
    g  = model_pick();
    eg = '0;
    ed = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ed    = bus.req_d[g*WIDTH +: WIDTH];
    end
    check("grant",     32'(bus.grant),     32'(eg));
    check("fifo_push", 32'(bus.fifo_push), 32'(g >= 0));
    check("fifo_d",    32'(bus.fifo_d),    32'(ed));
    check("owner",     32'(bus.owner),     32'(m_owner));
    check("locked",    32'(bus.locked),    32'(m_locked));
    check("burst_cnt", 32'(bus.burst_cnt), 32'(m_cnt));
    @(posedge clk);
    model_update(g);
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [REQ-1:0] r, input logic [REQ-1:0] l,
                       input logic full, input logic rs, input int n);
    bus.req       = r;
    bus.req_last  = l;
    bus.fifo_full = full;
    rst           = rs;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    cyc      = 0;
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    bus.req_d     = {8'h44, 8'h33, 8'h22, 8'h11};
    @(posedge clk);
    #1;
    model_update(-1);

    // Reset gating, then first grant goes to producer 0.
    drive(4'b1111, 4'b1111, 1'b0, 1'b0, 3);
    drive(4'b1111, 4'b1111, 1'b0, 1'b1, 1);

    // Round-robin over all four from a fresh pointer.
    drive(4'b1111, 4'b1111, 1'b0, 1'b0, 1);
    drive(4'b1111, 4'b1111, 1'b0, 1'b1, 5);

    // Full stall, then release.
    drive(4'b0101, 4'b1111, 1'b1, 1'b1, 3);
    drive(4'b0101, 4'b1111, 1'b0, 1'b1, 2);

    // Max-length burst by producer 1 starting with ptr at 1.
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1);
    drive(4'b0001, 4'b0001, 1'b0, 1'b1, 1);
    drive(4'b1010, 4'b0000, 1'b0, 1'b1, 5);
    drive(4'b1000, 4'b1000, 1'b0, 1'b1, 1);

    // Early end with full asserted mid-burst.
    drive(4'b1010, 4'b0000, 1'b0, 1'b1, 1);
    drive(4'b1010, 4'b0000, 1'b1, 1'b1, 2);
    drive(4'b1010, 4'b0010, 1'b0, 1'b1, 1);
    drive(4'b1010, 4'b0000, 1'b0, 1'b1, 1);
    drive(4'b1000, 4'b1000, 1'b0, 1'b1, 1);

    // Owner drops req while locked, then reset mid-burst.
    drive(4'b0010, 4'b0000, 1'b0, 1'b1, 1);
    drive(4'b1101, 4'b0000, 1'b0, 1'b1, 2);
    drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1);
    drive(4'b1110, 4'b1110, 1'b0, 1'b1, 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.req_d = {$urandom, $urandom};
      drive(REQ'($urandom), REQ'($urandom & $urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 63) != 0), 1);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
